// File: rtl/dbus_lsu.sv
// Load/store unit between execute and the data bus: one access in flight,
// alignment check at accept, byte-lane steering for stores, extension for loads.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_lsu
  import dbus_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_store_i,
  input  logic [2:0]      in_funct3_i,
  input  logic [XLEN-1:0] in_addr_i,
  input  logic [XLEN-1:0] in_wdata_i,
  input  logic [REGW-1:0] in_rd_i,
  input  logic            flush_i,
  output dbus_req_t       dreq_o,
  input  dbus_resp_t      dresp_i,
  output logic            wb_valid_o,
  output logic [REGW-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            done_o,
  output logic            misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            fault_q, fault_d;
  logic            flushed_q, flushed_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            accept;
  logic [2:0]      amask;
  logic            in_fault;
  logic [2:0]      off;
  logic [7:0]      lanes;
  logic [63:0]     sh;
  logic            sgn;
  logic [XLEN-1:0] load_ext;

  assign accept = in_valid_i && (state_q == IDLE);
  // Byte offset within the bus word; a 32-bit core only ever uses the low lanes.
  assign off    = (XLEN == 64) ? addr_q[2:0] : {1'b0, addr_q[1:0]};

  always_comb begin
    amask = 3'b000;
    lanes = 8'h01;
    case (in_funct3_i[1:0])
      2'd0: amask = 3'b000;
      2'd1: amask = 3'b001;
      2'd2: amask = 3'b011;
      default: amask = 3'b111;
    endcase
    case (funct3_q[1:0])
      2'd0: lanes = 8'h01;
      2'd1: lanes = 8'h03;
      2'd2: lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    in_fault = (|(in_addr_i[2:0] & amask)) || ((XLEN == 32) && (in_funct3_i[1:0] == 2'd3));
  end

  always_comb begin
    sh       = dresp_i.data >> {off, 3'b000};
    sgn      = ~funct3_q[2];
    load_ext = '0;
    case (funct3_q[1:0])
      2'd0: if (sgn) load_ext = XLEN'($signed(sh[7:0]));  else load_ext = XLEN'(sh[7:0]);
      2'd1: if (sgn) load_ext = XLEN'($signed(sh[15:0])); else load_ext = XLEN'(sh[15:0]);
      2'd2: if (sgn) load_ext = XLEN'($signed(sh[31:0])); else load_ext = XLEN'(sh[31:0]);
      default: load_ext = sh[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    fault_d   = fault_q;
    flushed_d = flushed_q;
    wb_data_d = wb_data_q;
    if (flush_i && (state_q != IDLE)) flushed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d   = in_store_i;
          funct3_d  = in_funct3_i;
          addr_d    = in_addr_i;
          wdata_d   = in_wdata_i;
          rd_d      = in_rd_i;
          fault_d   = in_fault;
          flushed_d = flush_i;
          state_d   = in_fault ? RESP : REQ;
        end
      end
      REQ: begin
        // data_ok without addr_ok is ignored: the request is still pending.
        if (dresp_i.addr_ok) begin
          if (dresp_i.data_ok) begin
            state_d = RESP;
            if (!store_q) wb_data_d = load_ext;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dresp_i.data_ok) begin
          state_d = RESP;
          if (!store_q) wb_data_d = load_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      store_q   <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      fault_q   <= fault_d;
      flushed_q <= flushed_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    dreq_o.valid  = (state_q == REQ);
    dreq_o.addr   = 64'(addr_q);
    dreq_o.size   = {1'b0, funct3_q[1:0]};
    dreq_o.strobe = store_q ? (lanes << off) : 8'h00;
    dreq_o.data   = 64'(wdata_q) << {off, 3'b000};
  end

  assign in_ready_o = (state_q == IDLE);
  assign done_o     = (state_q == RESP);
  assign misalign_o = done_o && fault_q;
  assign wb_valid_o = done_o && !store_q && !fault_q && !flushed_q;
  assign wb_rd_o    = rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_dbus_lsu.sv
// Bench for dbus_lsu: directed table, hand-written reset sequences, and
// randomized accesses checked against an arithmetic reference model.
module tb_dbus_lsu;
  import dbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic        v64, v32, in_store, flush;
  logic [2:0]  f3;
  logic [63:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  dbus_resp_t  dresp;

  logic        r64_ready, r32_ready, wbv64, wbv32, done64, done32, mis64, mis32;
  dbus_req_t   q64, q32;
  logic [4:0]  rd64, rd32;
  logic [63:0] wbd64;
  logic [31:0] wbd32;

  bit          sel32;
  logic        o_ready, o_wbv, o_done, o_mis;
  dbus_req_t   o_req;
  logic [4:0]  o_rd;
  logic [63:0] o_wbd;

  dbus_lsu #(.XLEN(64), .REGW(5)) u64 (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(v64), .in_ready_o(r64_ready),
    .in_store_i(in_store), .in_funct3_i(f3), .in_addr_i(in_addr), .in_wdata_i(in_wdata),
    .in_rd_i(in_rd), .flush_i(flush), .dreq_o(q64), .dresp_i(dresp),
    .wb_valid_o(wbv64), .wb_rd_o(rd64), .wb_data_o(wbd64), .done_o(done64), .misalign_o(mis64));

  dbus_lsu #(.XLEN(32), .REGW(5)) u32 (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(v32), .in_ready_o(r32_ready),
    .in_store_i(in_store), .in_funct3_i(f3), .in_addr_i(in_addr[31:0]), .in_wdata_i(in_wdata[31:0]),
    .in_rd_i(in_rd), .flush_i(flush), .dreq_o(q32), .dresp_i(dresp),
    .wb_valid_o(wbv32), .wb_rd_o(rd32), .wb_data_o(wbd32), .done_o(done32), .misalign_o(mis32));

  always_comb begin
    o_ready = sel32 ? r32_ready : r64_ready;
    o_req   = sel32 ? q32 : q64;
    o_wbv   = sel32 ? wbv32 : wbv64;
    o_rd    = sel32 ? rd32 : rd64;
    o_wbd   = sel32 ? {32'h0, wbd32} : wbd64;
    o_done  = sel32 ? done32 : done64;
    o_mis   = sel32 ? mis32 : mis64;
  end

  typedef struct {
    bit          sel32;
    bit          st;
    logic [2:0]  f3;
    logic [63:0] addr, wdata, rdata;
    int          a, d, bog, fl;
    bit          e_fault;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    bit          e_wbv;
    logic [63:0] e_wbd;
  } tv_t;

  tv_t tbl[16];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic tv_t mk(bit sel, bit st, logic [2:0] fn, logic [63:0] addr, logic [63:0] wd,
                             logic [63:0] rdat, int a, int d, int bog, int fl, bit ef,
                             logic [7:0] es, logic [63:0] ed, bit ew, logic [63:0] ewd);
    tv_t t;
    t.sel32 = sel; t.st = st; t.f3 = fn; t.addr = addr; t.wdata = wd; t.rdata = rdat;
    t.a = a; t.d = d; t.bog = bog; t.fl = fl;
    t.e_fault = ef; t.e_strobe = es; t.e_data = ed; t.e_wbv = ew; t.e_wbd = ewd;
    return t;
  endfunction

  // Reference: byte count, offset and extension computed with plain arithmetic.
  function automatic void model(inout tv_t v);
    int          nb, off;
    logic [63:0] wd, raw, lim;
    nb  = 1 << v.f3[1:0];
    off = v.sel32 ? int'(v.addr[1:0]) : int'(v.addr[2:0]);
    v.e_fault  = ((off % nb) != 0) || (v.sel32 && nb == 8);
    wd         = v.sel32 ? (v.wdata & 64'hFFFF_FFFF) : v.wdata;
    v.e_data   = wd << (8 * off);
    v.e_strobe = v.st ? 8'(((1 << nb) - 1) << off) : 8'h00;
    raw = v.rdata >> (8 * off);
    if (nb < 8) begin
      lim = 64'd1 << (8 * nb);
      raw = raw % lim;
      if (!v.f3[2] && raw >= (lim >> 1)) raw = raw - lim;
    end
    if (v.sel32) raw = raw & 64'hFFFF_FFFF;
    v.e_wbd = raw;
    v.e_wbv = !v.st && !v.e_fault && !(v.fl >= 0 && v.fl <= v.d);
  endfunction

  task automatic run_one(input tv_t v, input logic [4:0] rd, input string tag);
    int          done_c = 0, ready_c = 0, vcnt = 0, exp_done;
    bit          stable = 1'b1, captured = 1'b0;
    dbus_req_t   first;
    logic        mis = 1'b0, wbv = 1'b0;
    logic [63:0] wbd = '0, exp_addr;
    logic [4:0]  wrd = '0;
    first = '0;
    @(negedge clk);
    sel32 = v.sel32; in_store = v.st; f3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
    in_rd = rd; flush = (v.fl == 0);
    if (v.sel32) v32 = 1'b1; else v64 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      v64 = 1'b0; v32 = 1'b0;
      flush = (c == v.fl);
      if (o_req.valid) begin
        vcnt++;
        if (!captured) begin first = o_req; captured = 1'b1; end
        else if (o_req != first) stable = 1'b0;
      end
      if (done_c == 0 && o_done) begin
        done_c = c; mis = o_mis; wbv = o_wbv; wbd = o_wbd; wrd = o_rd;
      end
      if (ready_c == 0 && o_ready) ready_c = c;
      if (done_c != 0) begin
        dresp = '0;
        if (c > done_c) break;
      end else begin
        dresp.addr_ok = (c == v.a);
        dresp.data_ok = (c == v.d) || (c == v.bog);
        dresp.data    = (c == v.d) ? v.rdata : {$urandom, $urandom};
      end
    end
    flush = 1'b0;
    dresp = '0;
    exp_done = v.e_fault ? 1 : v.d + 1;
    exp_addr = v.sel32 ? {32'h0, v.addr[31:0]} : v.addr;
    chk({tag, "_done_seen"}, 64'(done_c != 0), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({tag, "_ready_cycle"}, 64'(ready_c), 64'(exp_done + 1));
    chk({tag, "_misalign"}, 64'(mis), 64'(v.e_fault));
    chk({tag, "_wb_valid"}, 64'(wbv), 64'(v.e_wbv));
    if (v.e_wbv) chk({tag, "_wb_data"}, wbd, v.e_wbd);
    chk({tag, "_wb_rd"}, 64'(wrd), 64'(rd));
    chk({tag, "_valid_cycles"}, 64'(vcnt), v.e_fault ? 64'd0 : 64'(v.a));
    if (!v.e_fault) begin
      chk({tag, "_strobe"}, 64'(first.strobe), 64'(v.e_strobe));
      chk({tag, "_data"}, first.data, v.e_data);
      chk({tag, "_size"}, 64'(first.size), 64'(v.f3[1:0]));
      chk({tag, "_addr"}, first.addr, exp_addr);
      chk({tag, "_stable"}, 64'(stable), 64'd1);
    end
    $display("txn %s x32=%0d st=%0d f3=%0d addr=%h done@%0d mis=%0d wbv=%0d wbd=%h",
             tag, v.sel32, v.st, v.f3, v.addr, done_c, mis, wbv, wbd);
  endtask

  initial begin
    int bad;
    tv_t r;
    rst_ni = 1'b0; v64 = 1'b0; v32 = 1'b0; in_store = 1'b0; flush = 1'b0;
    f3 = 3'd0; in_addr = '0; in_wdata = '0; in_rd = '0; dresp = '0; sel32 = 1'b0;

    tbl[0]  = mk(0, 0, 3'd2, 64'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 1, 1, 0, -1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_8000_0001);
    tbl[1]  = mk(0, 0, 3'd4, 64'h2003, 64'h0, 64'h0000_0000_AB00_0000, 2, 5, 0, -1, 0, 8'h00, 64'h0, 1, 64'hAB);
    tbl[2]  = mk(0, 1, 3'd1, 64'h3006, 64'h1234, 64'h0, 1, 1, 0, -1, 0, 8'hC0, 64'h1234_0000_0000_0000, 0, 64'h0);
    tbl[3]  = mk(0, 1, 3'd2, 64'h4002, 64'h55, 64'h0, 1, 1, 0, -1, 1, 8'h00, 64'h0, 0, 64'h0);
    tbl[4]  = mk(0, 0, 3'd3, 64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 4, 0, 2, 0, 8'h00, 64'h0, 0, 64'h0);
    tbl[5]  = mk(0, 0, 3'd3, 64'h5008, 64'h0, 64'hFEDC_BA98_7654_3210, 1, 1, 0, -1, 0, 8'h00, 64'h0, 1, 64'hFEDC_BA98_7654_3210);
    tbl[6]  = mk(0, 0, 3'd0, 64'h6001, 64'h0, 64'h0000_0000_0000_80FF, 1, 1, 0, 0, 0, 8'h00, 64'h0, 0, 64'h0);
    tbl[7]  = mk(0, 0, 3'd1, 64'h7002, 64'h0, 64'h0000_0000_8001_0000, 3, 5, 1, -1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8001);
    tbl[8]  = mk(1, 0, 3'd3, 64'h8000, 64'h0, 64'h0, 1, 1, 0, -1, 1, 8'h00, 64'h0, 0, 64'h0);
    tbl[9]  = mk(1, 1, 3'd0, 64'h9003, 64'hA5, 64'h0, 1, 1, 0, -1, 0, 8'h08, 64'hA500_0000, 0, 64'h0);
    tbl[10] = mk(1, 0, 3'd2, 64'hA004, 64'h0, 64'h0000_0000_F000_0000, 1, 2, 0, -1, 0, 8'h00, 64'h0, 1, 64'hF000_0000);
    tbl[11] = mk(1, 0, 3'd5, 64'hB002, 64'h0, 64'h0000_0000_9876_0000, 2, 2, 0, -1, 0, 8'h00, 64'h0, 1, 64'h9876);
    tbl[12] = mk(0, 0, 3'd1, 64'hC001, 64'h0, 64'h0, 1, 1, 0, -1, 1, 8'h00, 64'h0, 0, 64'h0);
    tbl[13] = mk(0, 0, 3'd3, 64'hC004, 64'h0, 64'h0, 1, 1, 0, -1, 1, 8'h00, 64'h0, 0, 64'h0);
    tbl[14] = mk(0, 0, 3'd6, 64'hD000, 64'h0, 64'h0000_0000_FFFF_FFFF, 1, 1, 0, -1, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF);
    tbl[15] = mk(0, 1, 3'd3, 64'hE000, 64'h1122_3344_5566_7788, 64'h0, 1, 1, 0, -1, 0, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0);

    repeat (2) @(negedge clk);
    chk("rst_ready64", 64'(r64_ready), 64'd1);
    chk("rst_ready32", 64'(r32_ready), 64'd1);
    chk("rst_dreq_valid", 64'(q64.valid), 64'd0);
    chk("rst_dreq_strobe", 64'(q64.strobe), 64'd0);
    chk("rst_dreq_addr", q64.addr, 64'd0);
    chk("rst_dreq_data", q64.data, 64'd0);
    chk("rst_dreq_size", 64'(q64.size), 64'd0);
    chk("rst_wb_valid", 64'(wbv64), 64'd0);
    chk("rst_done", 64'(done64), 64'd0);
    chk("rst_misalign", 64'(mis64), 64'd0);
    chk("rst_wb_data", wbd64, 64'd0);
    chk("rst_wb_rd", 64'(rd64), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(r64_ready), 64'd1);

    for (int i = 0; i < 16; i++) run_one(tbl[i], 5'(i + 1), $sformatf("tbl%0d", i));

    // Reset dropped while waiting for data; a late data_ok must be ignored.
    @(negedge clk);
    sel32 = 1'b0; v64 = 1'b1; in_store = 1'b0; f3 = 3'd3; in_addr = 64'hF000; in_rd = 5'd7;
    @(negedge clk);
    v64 = 1'b0;
    chk("rstw_valid_c1", 64'(q64.valid), 64'd1);
    dresp.addr_ok = 1'b1;
    @(negedge clk);
    dresp.addr_ok = 1'b0;
    chk("rstw_wait_valid", 64'(q64.valid), 64'd0);
    chk("rstw_wait_ready", 64'(r64_ready), 64'd0);
    rst_ni = 1'b0;
    #1;
    chk("rstw_in_rst_ready", 64'(r64_ready), 64'd1);
    chk("rstw_in_rst_valid", 64'(q64.valid), 64'd0);
    chk("rstw_in_rst_addr", q64.addr, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    dresp.data_ok = 1'b1; dresp.data = 64'hDEAD_DEAD_DEAD_DEAD;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      dresp.data_ok = 1'b0;
      if (done64 || wbv64 || !r64_ready || q64.valid) bad++;
    end
    chk("rstw_late_data_ok", 64'(bad), 64'd0);
    $display("txn rst_in_wait done");

    // Reset dropped in REQ: the bus request must vanish without waiting for a clock.
    @(negedge clk);
    v64 = 1'b1; f3 = 3'd2; in_addr = 64'h1230;
    @(negedge clk);
    v64 = 1'b0;
    chk("rstq_valid_c1", 64'(q64.valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rstq_valid_drop", 64'(q64.valid), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rstq_ready_after", 64'(r64_ready), 64'd1);
    $display("txn rst_in_req done");

    for (int i = 0; i < 200; i++) begin
      r.sel32 = 1'($urandom_range(0, 1));
      r.st    = 1'($urandom_range(0, 1));
      r.f3    = 3'($urandom_range(0, 7));
      r.addr  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) r.addr = r.addr & ~((64'd1 << r.f3[1:0]) - 64'd1);
      r.wdata = {$urandom, $urandom};
      r.rdata = {$urandom, $urandom};
      r.a     = $urandom_range(1, 3);
      r.d     = r.a + $urandom_range(0, 3);
      r.bog   = 0;
      r.fl    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, r.d) : -1;
      model(r);
      run_one(r, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
